dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressable data memory. Shares the single memory port between requester 0 (core load/store unit) and requester 1 (debug/DMA loader). It latches one request per transaction, drives the memory control, address and data for exactly one cycle, and returns a one-cycle response pulse to the granted requester. Illegal load/store encodings are rejected before they reach memory.

## Interface
- `ADDR_W`, 32: address width forwarded to memory.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `reqN_valid` in 1 (N=0,1): request present; must be held, with its fields, until `reqN_ready`.
- `reqN_ready` out 1: request accepted this cycle.
- `reqN_write` in 1: 1 = store, 0 = load.
- `reqN_funct3` in 3: RISC-V load/store width code.
- `reqN_addr` in ADDR_W: byte address.
- `reqN_wdata` in 32: store data.
- `rspN_valid` out 1: response pulse; no backpressure.
- `rspN_rdata` out 32: load data; 0 for stores and errors.
- `rspN_err` out 1: misaligned or illegal operation.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `mem_funct3` out 3: width code to memory.
- `mem_addr` out ADDR_W: address to memory.
- `mem_wdata` out 32: store data to memory.
- `mem_rdata` in 32: combinational read data from memory.
- `mem_misaligned` in 1: combinational alignment error from memory.

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE. Reset state is IDLE.
- **IDLE**
  - Arbitrate between the valid requests. Assert `ready` combinationally to the winner only.
  - On the accepting edge, latch write, funct3, addr, wdata and the grant id; go to ACCESS.
  - With no valid request, stay in IDLE.
- **ACCESS** (exactly 1 cycle)
  - Drive `mem_funct3`, `mem_addr` and `mem_wdata` from the latched request.
  - Assert `mem_read` for loads or `mem_write` for stores, unless the request is illegal.
  - At the end of the cycle, capture `mem_rdata` and `mem_misaligned`; go to RESP.
- **RESP** (exactly 1 cycle)
  - Pulse `rspN_valid` on the granted port with the captured data and error; go to IDLE.
  - `ready` is 0 on both ports in ACCESS and RESP.
- **Illegal encodings**
  - Store with funct3 not in {000, 001, 010}.
  - Load with funct3 in {011, 110, 111}.
  - Effect: neither `mem_read` nor `mem_write` asserts; response has `err`=1 and `rdata`=0.
- **Misaligned access** (`mem_misaligned`=1 during ACCESS): `err`=1, `rdata`=0. Memory has already suppressed the write.
- **Stores**: response has `rdata`=0 and `err` equal to the misaligned or illegal status.
- **Arbitration**: a policy register `last_grant` resets to 1, so port 0 wins the first tie. It updates on every accept. The policy itself is set under Configuration.
- **Reset mid-transaction**: asserting `rst_n` low immediately clears the FSM, the latched request and all outputs. The in-flight transaction is dropped with no response, and a store in ACCESS is not issued.

## Timing
- Request accepted at edge k → memory access during cycle k+1 → `rsp_valid` high during cycle k+2.
- Next accept no earlier than cycle k+3. Peak throughput is one transaction per 3 cycles.
- Store commits to memory at the edge ending cycle k+1.
- All outputs are registered, or decoded from registered state, except `reqN_ready`, which is combinational from `valid` and state.
- Reset values: `ready`, `rsp_valid`, `rsp_err`, `mem_read` and `mem_write` = 0. `rsp_rdata`, `mem_addr`, `mem_wdata` and `mem_funct3` = 0.

## Configuration
- Macro `DMEM_ARB_RR_EN`.
  - **Defined**: round-robin. On a tie, grant the port that is not `last_grant`.
  - **Undefined**: fixed priority. Port 0 always wins a tie, and `last_grant` is not implemented.
- Single-requester behaviour is identical in both modes.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the `NUM_REQ`=2 constant;
  - the legal-op check as a function.
- Sub-module `dmem_rr_arb2`: pure grant logic (valids, `last_grant` → one-hot grant), with the macro-selected policy inside it.

## Test plan
- **Store then load, port 0.** SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → `rsp0_rdata`=0xDEADBEEF, `err`=0, `rsp_valid` 2 cycles after accept.
- **Sign and zero extension.** SB 0x20 = 0x80, then LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080.
- **Misaligned load.** LW 0x22 → `rsp_err`=1, `rdata`=0, memory contents unchanged.
- **Illegal store.** Store with funct3=100 to 0x30 → `err`=1, `mem_write` never asserts, later LW 0x30 returns the prior value.
- **Contention.** Both ports hold valid continuously.
  - With `DMEM_ARB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: only port 0 is granted while it stays valid.
- **Reset mid-transaction.** Drop `rst_n` during ACCESS of SW 0x40 = 0x12345678 → no `rsp_valid`, all outputs 0; after release, LW 0x40 does not return 0x12345678 (memory preloaded with 0).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Width codes follow the RISC-V load/store funct3 encoding.
package dmem_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic op_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        else
            return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                   (funct3 == LBU) || (funct3 == LHU);
    endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-requester grant logic. DMEM_ARB_RR_EN selects round-robin on ties;
// otherwise port 0 has fixed priority and no grant history is needed.
module dmem_rr_arb2
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic               last_grant,
`endif
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            grant = last_grant ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the byte-addressable data memory.
// Optional round-robin arbitration via macro DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [2:0]        req0_funct3,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              rsp0_valid,
    output logic [31:0]       rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [2:0]        req1_funct3,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              rsp1_valid,
    output logic [31:0]       rsp1_rdata,
    output logic              rsp1_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_misaligned
);

    arb_state_e               state;
    logic [NUM_REQ-1:0]       valid_vec;
    logic [NUM_REQ-1:0]       grant;
    logic                     accept;

    logic                     sel_write;
    logic [2:0]               sel_funct3;
    logic [ADDR_W-1:0]        sel_addr;
    logic [31:0]              sel_wdata;
    logic                     sel_legal;

    logic                     gnt_id;
    logic                     write_q;
    logic                     illegal_q;
    logic [2:0]               funct3_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [31:0]              wdata_q;
    logic                     mem_read_q;
    logic                     mem_write_q;
    logic                     access_err;

    logic [NUM_REQ-1:0]       rsp_valid_q;
    logic [NUM_REQ-1:0]       rsp_err_q;
    logic [NUM_REQ-1:0][31:0] rsp_rdata_q;

`ifdef DMEM_ARB_RR_EN
    logic                     last_grant;
`endif

    assign valid_vec = {req1_valid, req0_valid};

    dmem_rr_arb2 u_arb (
`ifdef DMEM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .valid      (valid_vec),
        .grant      (grant)
    );

    assign accept     = (state == IDLE) && (grant != '0);
    assign req0_ready = (state == IDLE) && grant[0];
    assign req1_ready = (state == IDLE) && grant[1];

    always_comb begin
        sel_write  = grant[1] ? req1_write  : req0_write;
        sel_funct3 = grant[1] ? req1_funct3 : req0_funct3;
        sel_addr   = grant[1] ? req1_addr   : req0_addr;
        sel_wdata  = grant[1] ? req1_wdata  : req0_wdata;
        sel_legal  = op_legal(sel_write, sel_funct3);
    end

    assign access_err = illegal_q || mem_misaligned;

    // Legality is resolved at accept so the memory strobes leave a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_id      <= 1'b0;
            write_q     <= 1'b0;
            illegal_q   <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_id      <= grant[1];
                        write_q     <= sel_write;
                        illegal_q   <= !sel_legal;
                        funct3_q    <= sel_funct3;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        mem_read_q  <= sel_legal && !sel_write;
                        mem_write_q <= sel_legal && sel_write;
`ifdef DMEM_ARB_RR_EN
                        last_grant  <= grant[1];
`endif
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read_q          <= 1'b0;
                    mem_write_q         <= 1'b0;
                    rsp_valid_q[gnt_id] <= 1'b1;
                    rsp_err_q[gnt_id]   <= access_err;
                    rsp_rdata_q[gnt_id] <= (write_q || access_err) ? '0 : mem_rdata;
                    state               <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_funct3 = funct3_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp0_rdata = rsp_rdata_q[0];
    assign rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressable memory model.
// Contention expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_write;
    logic [2:0]  req0_funct3;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [2:0]  req1_funct3;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic        mem_read, mem_write, mem_misaligned;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_funct3(req0_funct3), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_funct3(req1_funct3), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_misaligned(mem_misaligned)
    );

    // Memory model: combinational read with extension, write on the clock edge.
    logic [7:0] mem [256];
    logic [7:0] ma;
    assign ma = mem_addr[7:0];

    always_comb begin
        mem_misaligned = 1'b0;
        mem_rdata      = '0;
        case (mem_funct3)
            3'b000: mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
            3'b100: mem_rdata = {24'h0, mem[ma]};
            3'b001: mem_rdata = {{16{mem[8'(ma+1)][7]}}, mem[8'(ma+1)], mem[ma]};
            3'b101: mem_rdata = {16'h0, mem[8'(ma+1)], mem[ma]};
            3'b010: mem_rdata = {mem[8'(ma+3)], mem[8'(ma+2)], mem[8'(ma+1)], mem[ma]};
            default: mem_rdata = '0;
        endcase
        if (mem_funct3 == 3'b001 || mem_funct3 == 3'b101) mem_misaligned = ma[0];
        if (mem_funct3 == 3'b010) mem_misaligned = (ma[1:0] != 2'b00);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_write && !mem_misaligned) begin
            mem[ma] <= mem_wdata[7:0];
            if (mem_funct3 != 3'b000) mem[8'(ma+1)] <= mem_wdata[15:8];
            if (mem_funct3 == 3'b010) begin
                mem[8'(ma+2)] <= mem_wdata[23:16];
                mem[8'(ma+3)] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_write = w; req0_funct3 = f3; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_funct3 = f3; req1_addr = a; req1_wdata = d;
        end
    endtask

    // One full transaction; reports response and memory strobes seen in ACCESS.
    task automatic do_req(input string tag, input int p, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output logic rd_seen,
                          output logic wr_seen);
        int n = 0;
        rd = '0; er = 1'b0; rd_seen = 1'b0; wr_seen = 1'b0;
        @(negedge clk);
        drive(p, 1'b1, w, f3, a, d);
        #1;
        while (!(p == 0 ? req0_ready : req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_accept"}, 32'(n < 20), 32'd1);
        if (n < 20) begin
            @(posedge clk); #1;
            drive(p, 1'b0, w, f3, a, d);
            @(negedge clk);
            check({tag, "_lat_k1"}, 32'(p == 0 ? rsp0_valid : rsp1_valid), 32'd0);
            rd_seen = mem_read;
            wr_seen = mem_write;
            @(negedge clk);
            check({tag, "_lat_k2"}, 32'(p == 0 ? rsp0_valid : rsp1_valid), 32'd1);
            rd = (p == 0) ? rsp0_rdata : rsp1_rdata;
            er = (p == 0) ? rsp0_err : rsp1_err;
        end else begin
            drive(p, 1'b0, w, f3, a, d);
        end
    endtask

    logic [31:0] rd;
    logic        er, rs, ws;
    int          grants [4];
    int          exp_g  [4];
    int          gi;
    int          seen;

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #23;
        check("rst_ctrl", {24'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                           rsp0_err, rsp1_err, mem_read, mem_write}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rsp0_rdata | rsp1_rdata | {29'h0, mem_funct3}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention straight out of reset, both ports held valid.
`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        gi = 0;
        for (int c = 0; c < 40 && gi < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) begin grants[gi] = 2; gi++; end
            else if (req0_ready) begin grants[gi] = 0; gi++; end
            else if (req1_ready) begin grants[gi] = 1; gi++; end
            if (gi < 4) @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b010, 32'h4, 32'h0);
        check("cont_count", gi, 4);
        for (int i = 0; i < 4; i++) check($sformatf("cont_grant%0d", i), grants[i], exp_g[i]);
        repeat (2) @(negedge clk);

        do_req("sw10", 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, rs, ws);
        check("sw10_rsp", {rd[30:0], er}, 32'h0);
        check("sw10_strobe", {30'h0, rs, ws}, 32'h1);
        do_req("lw10", 0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, rs, ws);
        check("lw10_data", rd, 32'hDEADBEEF);
        check("lw10_err", er, 0);
        check("lw10_strobe", {30'h0, rs, ws}, 32'h2);

        do_req("sb20", 0, 1'b1, 3'b000, 32'h20, 32'h00000080, rd, er, rs, ws);
        do_req("lb20", 0, 1'b0, 3'b000, 32'h20, 32'h0, rd, er, rs, ws);
        check("lb20_data", rd, 32'hFFFFFF80);
        do_req("lbu20", 0, 1'b0, 3'b100, 32'h20, 32'h0, rd, er, rs, ws);
        check("lbu20_data", rd, 32'h00000080);

        do_req("lw22", 0, 1'b0, 3'b010, 32'h22, 32'h0, rd, er, rs, ws);
        check("lw22_err", er, 1);
        check("lw22_data", rd, 32'h0);
        do_req("lw20", 0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, rs, ws);
        check("lw20_after_mis", rd, 32'h00000080);

        do_req("sw30", 0, 1'b1, 3'b010, 32'h30, 32'h11223344, rd, er, rs, ws);
        do_req("ill_st", 0, 1'b1, 3'b100, 32'h30, 32'hCAFEF00D, rd, er, rs, ws);
        check("ill_st_err", er, 1);
        check("ill_st_data", rd, 32'h0);
        check("ill_st_strobe", {30'h0, rs, ws}, 32'h0);
        do_req("lw30", 0, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, rs, ws);
        check("lw30_data", rd, 32'h11223344);

        do_req("ill_ld", 0, 1'b0, 3'b011, 32'h30, 32'h0, rd, er, rs, ws);
        check("ill_ld_err", er, 1);
        check("ill_ld_rsp", {rd[29:0], rs, ws}, 32'h0);

        do_req("p1_sh", 1, 1'b1, 3'b001, 32'h50, 32'h0000ABCD, rd, er, rs, ws);
        check("p1_sh_err", er, 0);
        do_req("p1_lhu", 1, 1'b0, 3'b101, 32'h50, 32'h0, rd, er, rs, ws);
        check("p1_lhu_data", rd, 32'h0000ABCD);
        do_req("p1_lh", 1, 1'b0, 3'b001, 32'h50, 32'h0, rd, er, rs, ws);
        check("p1_lh_data", rd, 32'hFFFFABCD);

        // Reset asserted during ACCESS of SW 0x40.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678);
        gi = 0;
        #1;
        while (!req0_ready && gi < 20) begin @(negedge clk); #1; gi++; end
        check("rst_sw_accept", 32'(gi < 20), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
        @(negedge clk);
        check("rst_sw_access", mem_write, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {24'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                              rsp0_err, rsp1_err, mem_read, mem_write}, 32'h0);
        check("midrst_bus", mem_addr | mem_wdata | rsp0_rdata | rsp1_rdata | {29'h0, mem_funct3}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin @(negedge clk); if (rsp0_valid || rsp1_valid) seen++; end
        check("midrst_no_rsp", seen, 0);
        do_req("lw40", 0, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, rs, ws);
        check("lw40_data", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
